// File: rtl/intt_job_sched_pkg.sv
// intt_sched_pkg: state encoding, mode constants and default timeouts for the engine scheduler
package intt_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_RUN, S_RESP} state_t;
  localparam logic MODE_NTT = 1'b0;
  localparam logic MODE_INTT = 1'b1;
  localparam int DEF_ARM_TIMEOUT = 8;
  localparam int DEF_RUN_TIMEOUT = 8192;
endpackage

// File: rtl/intt_job_sched_if.sv
// intt_job_sched_if: requester and engine handshake bundle around the scheduler
interface intt_job_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int Q_SEL_W = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_mode;
  logic [NUM_REQ*Q_SEL_W-1:0] req_q;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] cmp;
  logic cmp_err;
  logic eng_start;
  logic eng_mode;
  logic [Q_SEL_W-1:0] eng_q_sel;
  logic eng_done;
  modport master (
    output req, req_mode, req_q, eng_done,
    input gnt, cmp, cmp_err, eng_start, eng_mode, eng_q_sel
  );
  modport slave (
    input req, req_mode, req_q, eng_done,
    output gnt, cmp, cmp_err, eng_start, eng_mode, eng_q_sel
  );
endinterface

// File: rtl/intt_job_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester at or above ptr, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  // scan offsets from farthest to nearest so the closest requester at or after ptr wins
  always_comb begin
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) begin
        idx = j;
        valid = 1'b1;
      end
    end
    gnt = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/intt_job_sched.sv
// intt_job_sched: shares one NTT/INTT engine among requesters with round-robin jobs and timeouts
module intt_job_sched
  import intt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int Q_SEL_W = 2,
  parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT,
  parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  intt_job_sched_if.slave  bus,
  output logic             sched_busy,
  output logic [CYC_W-1:0] run_cycles,
  output logic             err_sticky
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [31:0] CYC_MAX = 32'((64'd1 << CYC_W) - 64'd1);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, cmp_q, cmp_d, pick_gnt;
  logic [IW-1:0] own_q, own_d, ptr_q, ptr_d, pick_idx;
  logic [Q_SEL_W-1:0] qsel_q, qsel_d;
  logic [CYC_W-1:0] run_q, run_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic pick_valid;
  logic cmp_err_q, cmp_err_d, start_q, start_d, mode_q, mode_d;
  logic tmo_q, tmo_d, busy_q, busy_d, err_q, err_d;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cnt_inc = cnt_q + 32'd1;
  assign bus.gnt = gnt_q;
  assign bus.cmp = cmp_q;
  assign bus.cmp_err = cmp_err_q;
  assign bus.eng_start = start_q;
  assign bus.eng_mode = mode_q;
  assign bus.eng_q_sel = qsel_q;
  assign sched_busy = busy_q;
  assign run_cycles = run_q;
  assign err_sticky = err_q;

  // next-state and next-output logic; outputs are precomputed so every one leaves a flop
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    cmp_d = '0;
    cmp_err_d = 1'b0;
    start_d = 1'b0;
    mode_d = mode_q;
    qsel_d = qsel_q;
    own_d = own_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    run_d = run_q;
    err_d = err_q;
    case (state_q)
      S_IDLE:
        if (pick_valid) begin
          state_d = S_ISSUE;
          gnt_d = pick_gnt;
          own_d = pick_idx;
          start_d = 1'b1;
          tmo_d = 1'b0;
          mode_d = bus.req_mode[pick_idx];
          qsel_d = bus.req_q[pick_idx * Q_SEL_W +: Q_SEL_W];
        end
      S_ISSUE: begin
        state_d = S_ARM;
        cnt_d = '0;
      end
      S_ARM:
        if (!bus.eng_done) begin
          state_d = S_RUN;
          cnt_d = '0;
        end else if (cnt_inc == 32'(ARM_TIMEOUT)) begin
          state_d = S_RESP;
          tmo_d = 1'b1;
          run_d = '0;
        end else
          cnt_d = cnt_inc;
      S_RUN:
        if (bus.eng_done || cnt_inc == 32'(RUN_TIMEOUT)) begin
          state_d = S_RESP;
          tmo_d = !bus.eng_done;
          run_d = cnt_inc > CYC_MAX ? '1 : CYC_W'(cnt_inc);
        end else
          cnt_d = cnt_inc;
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d = '0;
        ptr_d = own_q == IW'(NUM_REQ - 1) ? '0 : own_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP) begin
      cmp_d = gnt_q;
      cmp_err_d = tmo_d;
      err_d = err_q | tmo_d;
    end
    busy_d = state_d != S_IDLE;
  end

  // state and registered outputs; reset aborts any job in flight without a completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q <= '0;
      cmp_q <= '0;
      cmp_err_q <= 1'b0;
      start_q <= 1'b0;
      mode_q <= MODE_NTT;
      qsel_q <= '0;
      own_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
      run_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      cmp_q <= cmp_d;
      cmp_err_q <= cmp_err_d;
      start_q <= start_d;
      mode_q <= mode_d;
      qsel_q <= qsel_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      run_q <= run_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
endmodule

// File: doc/intt_job_sched.md
Name: intt_job_sched

Overview:
- Shares one NTT/INTT engine (control unit plus butterfly datapath) among NUM_REQ requesters, e.g. key-switch, rescale and host DMA.
- Performs round-robin selection and latches the chosen job's mode and modulus select.
- Issues the 1-cycle start pulse and tracks the engine's level-type done signal through its full pipeline drain.
- Returns a completion pulse to the owner and steers the coefficient-BRAM port muxes via a one-hot owner vector.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- Q_SEL_W, 2, width of modulus-select field per requester.
- ARM_TIMEOUT, 8, max cycles after start for eng_done to fall.
- RUN_TIMEOUT, 8192, max cycles for eng_done to return high once low.
- CYC_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester job request; level, held until cmp.
- req_mode  in  NUM_REQ  per-requester mode: 0 = NTT, 1 = INTT.
- req_q  in  NUM_REQ*Q_SEL_W  per-requester modulus select, packed, requester i at [i*Q_SEL_W +: Q_SEL_W].
- gnt  out  NUM_REQ  one-hot owner; high from grant through completion pulse; drives BRAM port muxes.
- cmp  out  NUM_REQ  one-cycle completion pulse to owner.
- cmp_err  out  1  qualifies cmp: job ended by timeout.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_mode  out  1  latched mode, stable while gnt is nonzero.
- eng_q_sel  out  Q_SEL_W  latched modulus select, stable while gnt is nonzero.
- eng_done  in  1  engine idle level; high when idle, low while busy.
- sched_busy  out  1  high in any state other than IDLE.
- run_cycles  out  CYC_W  cycles spent in RUN by the last job; saturates at all-ones.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; latched config 0. Reset mid-job aborts immediately, with no cmp; the engine self-recovers on its own reset.
- States: IDLE, ISSUE, ARM, RUN, RESP. All outputs are registered.
- IDLE:
  - If req is nonzero, pick the first set bit at or above the rr pointer, wrapping modulo NUM_REQ.
  - Register gnt one-hot, eng_mode and eng_q_sel from that requester. Go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: eng_start = 1 for exactly this cycle. Clear arm/run counter. Go to ARM.
- ARM:
  - Wait for eng_done == 0, because the engine's done is still high on the start cycle and the next one. Then clear the counter and go to RUN.
  - If the counter reaches ARM_TIMEOUT, set the timeout flag and go to RESP.
- RUN:
  - Count each cycle into run_cycles; the counter saturates at all-ones.
  - When eng_done == 1, go to RESP.
  - If the counter reaches RUN_TIMEOUT, set the timeout flag and go to RESP.
- RESP:
  - cmp[owner] = 1 for one cycle; cmp_err = timeout flag.
  - gnt is still asserted this cycle, then cleared on exit.
  - rr pointer = (owner + 1) mod NUM_REQ. err_sticky |= timeout flag. Go to IDLE.
- Minimum gap: one IDLE cycle between RESP and the next grant, so gnt stays 0 for at least one cycle when switching owners.
- Request changes after grant: the owner dropping req during ISSUE/ARM/RUN is ignored and the job completes with cmp. Changes to req_mode/req_q after grant are not observed.
- Simultaneous requests: round-robin guarantees each of N continuously requesting clients is served within N jobs.
- eng_done glitch high during RUN is treated as completion; the engine guarantees a monotonic done.
- Latency: req rise to eng_start is 2 cycles (IDLE decision, ISSUE). Engine done to cmp is 1 cycle.

Decomposition:
- Package intt_sched_pkg: state encoding, MODE_NTT/MODE_INTT constants, default timeouts.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req and pointer.
  - Outputs: one-hot grant, encoded index, valid.
  - Instantiated once.

Test Plan:
- Single request: req=4'b0001, mode=1, q=2; engine model drops done 2 cycles after start, raises it 6155 cycles later -> eng_start at cycle 2; gnt=0001, eng_mode=1, eng_q_sel=2 throughout; cmp[0] one cycle; run_cycles=6155; cmp_err=0.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; each cmp precedes the next gnt by at least 1 cycle of gnt=0.
- Pointer=2 with req=4'b1011 -> grant to 3, then 0, then 1.
- Engine never drops done -> after ARM_TIMEOUT=8 cycles: cmp pulse with cmp_err=1, err_sticky=1, next request still served.
- Engine stuck busy -> RUN_TIMEOUT expiry produces cmp_err=1 and run_cycles=8192.
- rst_n asserted mid-RUN -> gnt, cmp, eng_start, sched_busy all 0 asynchronously; after release, a pending req=0001 is granted with pointer reset to 0.
